// File: rtl/dvp_capture_pkg.sv
// Shared constants and state types for the DVP capture register block.
package dvp_capture_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_BASE = 2'd1;
  localparam logic [1:0] REG_SIZE = 2'd2;
  localparam logic [1:0] REG_AUX  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/dvp_capture_regs.sv
// AXI4-Lite slave exposing four 32-bit capture configuration registers
// plus a one-cycle start pulse on a reg0 bit0 write.
module dvp_capture_regs
  import dvp_capture_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
  output logic                            ctrl_start
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  awready_q, awready_d;
  logic                  arready_q, arready_d;
  logic                  start_q, start_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [3:0][DW-1:0]    regs_q, regs_d;

  logic [1:0] widx, ridx;
  logic       wr_hs, rd_hs;
  logic       unused_addr_lsb;

  assign widx  = S_AXI_AWADDR[3:2];
  assign ridx  = S_AXI_ARADDR[3:2];
  assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready is registered, so it can only rise on the edge after reset
  // release and a handshake lands on the second edge at the earliest.
  assign wr_hs = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs = arready_q && S_AXI_ARVALID;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    regs_d    = regs_q;
    start_d   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (wr_hs) begin
          for (int k = 0; k < NB; k++)
            if (S_AXI_WSTRB[k]) regs_d[widx][8*k +: 8] = S_AXI_WDATA[8*k +: 8];
          start_d   = (widx == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
          w_state_d = W_RESP;
        end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read data is sampled from the pre-edge register contents, so a
  // coincident write to the same index is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = 1'b0;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_hs) begin
          rdata_d   = regs_q[ridx];
          r_state_d = R_DATA;
        end else if (S_AXI_ARVALID) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      start_q   <= 1'b0;
      rdata_q   <= '0;
      regs_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      start_q   <= start_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = (w_state_q == W_RESP);
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = (r_state_q == R_DATA);
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = rdata_q;
  assign ctrl_start    = start_q;

  assign cfg_reg0 = regs_q[REG_CTRL];
  assign cfg_reg1 = regs_q[REG_BASE];
  assign cfg_reg2 = regs_q[REG_SIZE];
  assign cfg_reg3 = regs_q[REG_AUX];

endmodule

// File: tb/tb_dvp_capture_regs.sv
// Directed plus randomized AXI4-Lite traffic against a register-array model.
module tb_dvp_capture_regs;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, cfg0, cfg1, cfg2, cfg3;
  logic        ctrl_start;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] model [4];

  dvp_capture_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .cfg_reg0(cfg0), .cfg_reg1(cfg1), .cfg_reg2(cfg2), .cfg_reg3(cfg3),
    .ctrl_start(ctrl_start)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] cfg_of(input logic [1:0] idx);
    case (idx)
      2'd0: return cfg0;
      2'd1: return cfg1;
      2'd2: return cfg2;
      default: return cfg3;
    endcase
  endfunction

  function automatic void model_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 32'hFF << (8 * k);
      if (s[k]) model[idx] = (model[idx] & ~m) | (d & m);
    end
  endfunction

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit got = 0;
    logic exp_start;
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1; WVALID = 1;
    for (int i = 0; i < 20 && !got; i++) begin cyc(); got = AWREADY && WREADY; end
    chk("wr_ready_seen", {31'd0, got}, 32'd1);
    cyc();
    AWVALID = 0; WVALID = 0;
    model_write(addr[3:2], data, strb);
    exp_start = (addr[3:2] == 2'd0) && strb[0] && data[0];
    chk("ctrl_start_pulse", {31'd0, ctrl_start}, {31'd0, exp_start});
    chk("bvalid_up", {31'd0, BVALID}, 32'd1);
    chk("bresp", {30'd0, BRESP}, 32'd0);
    chk("cfg_after_wr", cfg_of(addr[3:2]), model[addr[3:2]]);
    BREADY = 1; cyc(); BREADY = 0;
    chk("bvalid_down", {31'd0, BVALID}, 32'd0);
    chk("ctrl_start_low", {31'd0, ctrl_start}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr);
    bit got = 0;
    ARADDR = addr; ARVALID = 1;
    for (int i = 0; i < 20 && !got; i++) begin cyc(); got = ARREADY; end
    chk("rd_ready_seen", {31'd0, got}, 32'd1);
    cyc();
    ARVALID = 0;
    chk("rvalid_up", {31'd0, RVALID}, 32'd1);
    chk("rdata", RDATA, model[addr[3:2]]);
    chk("rresp", {30'd0, RRESP}, 32'd0);
    RREADY = 1; cyc(); RREADY = 0;
    chk("rvalid_down", {31'd0, RVALID}, 32'd0);
  endtask

  initial begin
    ARESETN = 0; AWADDR = 0; ARADDR = 0; AWVALID = 0; WVALID = 0; BREADY = 0;
    ARVALID = 0; RREADY = 0; WDATA = 0; WSTRB = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    repeat (3) @(posedge ACLK);
    #2;
    chk("rst_ready", {28'd0, AWREADY, WREADY, ARREADY, BVALID}, 32'd0);
    chk("rst_rvalid_start", {30'd0, RVALID, ctrl_start}, 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_cfg", cfg0 | cfg1 | cfg2 | cfg3, 32'd0);
    ARESETN = 1;
    cyc();

    // Basic write/read of all four registers.
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));
    chk("cfg0_1", cfg0, 32'd1); chk("cfg3_4", cfg3, 32'd4);

    // Partial strobe: only byte 1 replaced.
    axi_write(4'h4, 32'h00000002, 4'hF);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010);
    axi_read(4'h4);
    chk("strb_literal", cfg1, 32'h0000CC02);

    // AW ahead of W, then held B response blocks a second write.
    AWADDR = 4'h8; WDATA = 32'h3; WSTRB = 4'hF; AWVALID = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_early_accept", {30'd0, AWREADY, WREADY}, 32'd0);
    end
    WVALID = 1;
    cyc();
    chk("ready_in_wvalid", {30'd0, AWREADY, WREADY}, 32'd3);
    cyc();
    model_write(2'd2, 32'h3, 4'hF);
    WDATA = 32'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bvalid_held", {31'd0, BVALID}, 32'd1);
      chk("blocked_while_b", {30'd0, AWREADY, WREADY}, 32'd0);
      cyc();
    end
    chk("cfg2_not_overwritten", cfg2, 32'h3);
    BREADY = 1; cyc(); BREADY = 0;
    AWVALID = 0; WVALID = 0;
    chk("b_done", {31'd0, BVALID}, 32'd0);

    // Coincident read and write to the same register.
    AWADDR = 4'h8; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    ARADDR = 4'h8; ARVALID = 1;
    cyc();
    chk("both_ready", {30'd0, AWREADY, ARREADY}, 32'd3);
    cyc();
    AWVALID = 0; WVALID = 0; ARVALID = 0;
    chk("same_cycle_old", RDATA, model[2]);
    model_write(2'd2, 32'h55, 4'hF);
    chk("same_cycle_resp", {30'd0, BVALID, RVALID}, 32'd3);
    BREADY = 1; RREADY = 1; cyc(); BREADY = 0; RREADY = 0;
    axi_read(4'h8);

    // Start pulse only for bit0 set.
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h1, 32'h1, 4'b0001);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)));
      else
        axi_read(a);
      repeat ($urandom_range(0, 2)) cyc();
    end

    // Reset while a write response is pending.
    AWADDR = 4'h4; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    cyc(); cyc();
    AWVALID = 0; WVALID = 0;
    chk("pre_rst_bvalid", {31'd0, BVALID}, 32'd1);
    #2 ARESETN = 0;
    #1;
    for (int i = 0; i < 4; i++) model[i] = 32'd0;
    chk("rst_bvalid_async", {31'd0, BVALID}, 32'd0);
    chk("rst_cfg_async", cfg0 | cfg1 | cfg2 | cfg3, 32'd0);
    cyc();
    ARESETN = 1;
    cyc();
    chk("post_rst_bvalid", {31'd0, BVALID}, 32'd0);
    axi_read(4'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dvp_capture_regs.md
DVP_CAPTURE_REGS -- requirements
Module: dvp_capture_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (four 32-bit registers).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: ACLK  in  1  sole clock, all logic rising-edge.
REQ-004 ARESETN  in  1  asynchronous active-low reset.
REQ-005 S_AXI_AWADDR  in  4  write address; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-006 S_AXI_WDATA  in  32  write data; S_AXI_WSTRB in 4 byte enables; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-007 S_AXI_BRESP  out  2  write response; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-008 S_AXI_ARADDR  in  4  read address; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-009 S_AXI_RDATA  out  32  read data; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-010 cfg_reg0..cfg_reg3  out  32 each  current register contents to capture logic.
REQ-011 ctrl_start  out  1  one-cycle pulse on write of reg0 with bit0 set.

Function
REQ-012 SHALL decode register index from AWADDR[3:2]/ARADDR[3:2]; AWADDR/ARADDR[1:0] ignored; all four registers read/write, 32 bits, no reserved bits.
REQ-013 Write FSM states W_IDLE, W_RESP; AWPROT/ARPROT not implemented.
REQ-014 W_IDLE: AWREADY and WREADY asserted together for exactly one cycle only when AWVALID and WVALID both high; else both low (no early accept of either channel).
REQ-015 On write handshake: byte k of addressed register updated at the same edge iff WSTRB[k]; go to W_RESP with BVALID=1, BRESP=2'b00.
REQ-016 W_RESP: BVALID held until BREADY sampled high, then W_IDLE; no new write accepted while BVALID=1; at most one write outstanding.
REQ-017 ctrl_start SHALL be high the cycle after a write handshake to index 0 with WSTRB[0]=1 and WDATA[0]=1; low otherwise; not stored (reg0 bit0 still holds written value).
REQ-018 Read FSM states R_IDLE, R_DATA.
REQ-019 R_IDLE: ARREADY high for one cycle when ARVALID high; RDATA captured from addressed register at that edge; go to R_DATA.
REQ-020 R_DATA: RVALID=1, RRESP=2'b00, RDATA stable until RREADY sampled high, then R_IDLE; ARREADY low throughout.
REQ-021 Read and write channels independent; same-cycle read and write handshakes to same register: read returns pre-write value.
REQ-022 Read latency: RVALID first high one cycle after AR handshake; write visible on cfg_regN and to reads the cycle after W handshake.
REQ-023 BRESP and RRESP SHALL always be OKAY; no SLVERR/DECERR.

Reset
REQ-024 ARESETN low SHALL asynchronously clear: all registers to 0, AWREADY, WREADY, BVALID, ARREADY, RVALID, ctrl_start to 0, RDATA to 0, BRESP/RRESP to 0, FSMs to idle.
REQ-025 Reset mid-transaction SHALL abandon it with no response issued; first accept allowed on second rising edge after ARESETN deasserts.

Structure
REQ-026 Shared package dvp_capture_pkg SHALL hold register index constants (REG_CTRL=0, REG_BASE=1, REG_SIZE=2, REG_AUX=3), FSM state enums, AXI response constants.
REQ-027 Single module, no sub-modules; register array written only by write FSM.

Verification
REQ-028 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC then read same -> RDATA 0x1..0x4, all RESP OKAY, cfg_reg0..3 = 1..4.
REQ-029 reg1=0x00000002, write 0xAABBCCDD to 0x4 with WSTRB=4'b0010 -> read 0x0000CC02.
REQ-030 AWVALID 3 cycles before WVALID, BREADY low 5 cycles -> AWREADY/WREADY only in W-valid cycle, BVALID held 5 cycles, second write not accepted until B handshake.
REQ-031 Same-cycle write 0x55 and read at 0x8 (old 0x3) -> RDATA 0x3; subsequent read 0x55.
REQ-032 Write 0x1 to 0x0 -> ctrl_start high exactly one cycle; write 0x0 -> no pulse.
REQ-033 ARESETN low while BVALID=1 -> BVALID low immediately, all cfg_reg 0, read of 0x4 after release returns 0.
